multdiv_sequencer: RTL and testbench
====================================

# multdiv_sequencer

Multi-cycle sequencer for the multiply/divide unit of the 5-stage pipeline. Watches the instruction in the DX stage, and on a `mul` or `div` it:
- latches the operands and the destination register;
- issues a single-cycle start pulse to the multdiv unit;
- holds the front of the pipeline (PC, FD, DX) stalled until the unit reports ready or a timeout expires;
- presents the result for one cycle so the processor muxes it into the XM latch in place of the ALU output.

## Interface

Parameters:
- `MAX_CYCLES`, 40: WAIT cycles allowed before the operation is forced to complete with an exception.
- `CNT_W`, 6: width of the wait counter. Must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- `clock`  in  1  master clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dx_ir`  in  32  instruction currently held in the DX latch.
- `dx_a`  in  32  DX operand A (post-bypass).
- `dx_b`  in  32  DX operand B (post-bypass).
- `md_result`  in  32  result from the multdiv unit.
- `md_exception`  in  1  multdiv exception (overflow, divide by zero); valid with `md_ready`.
- `md_ready`  in  1  multdiv result-ready strobe.
- `md_ctrl_mult`  out  1  one-cycle start pulse, multiply.
- `md_ctrl_div`  out  1  one-cycle start pulse, divide.
- `md_operand_a`  out  32  latched operand A, held stable from START until the return to IDLE.
- `md_operand_b`  out  32  latched operand B, same hold rule as A.
- `stall`  out  1  freeze PC/FD/DX and insert a nop into XM.
- `busy`  out  1  high in START and WAIT.
- `result_valid`  out  1  one-cycle strobe, high in DONE.
- `result`  out  32  latched result, or 0 on timeout.
- `result_ovf`  out  1  latched `md_exception`, or 1 on timeout.
- `result_rd`  out  5  latched destination register, taken from `dx_ir[26:22]`.

## Operation

- Decode:
  - `is_md` = (`dx_ir[31:27]` == 5'b00000) & (`dx_ir[6:2]` == 5'b00110 for mul or 5'b00111 for div).
  - Every other instruction is ignored.
- Registered states are IDLE, START, WAIT, DONE (2-bit encoding).
- IDLE:
  - If `is_md`: latch `dx_a`, `dx_b`, `dx_ir[26:22]` and the op (mul or div), then go to START.
  - Otherwise stay in IDLE.
- START:
  - Drive `md_ctrl_mult` or `md_ctrl_div` high for this cycle only, per the latched op.
  - Clear the counter and go to WAIT.
  - `md_ready` is ignored in this state.
- WAIT:
  - If `md_ready`: latch `md_result` into `result` and `md_exception` into `result_ovf`, then go to DONE.
  - Else if counter == `MAX_CYCLES`-1: set `result` = 0 and `result_ovf` = 1, then go to DONE.
  - Otherwise increment the counter.
- DONE:
  - `result_valid` = 1 and `stall` = 0, so the instruction in DX advances to XM carrying the result.
  - Unconditionally go to IDLE. `dx_ir` is not re-decoded in DONE, so the same instruction is never re-issued.
- Output equations:
  - `stall` = ~`reset` & ((IDLE & `is_md`) | START | WAIT). This is combinational; the first stall cycle is the detection cycle itself.
  - `busy` = START | WAIT.
- Back-to-back mul/div: the second instruction reaches DX the cycle after DONE, finds the block in IDLE, and starts a fresh sequence with no extra bubble.
- `md_ready` outside WAIT is ignored and does not alter state.
- Reset, in any state including mid-operation:
  - Next state is IDLE; counter, `result`, `result_ovf`, `result_rd` and operand latches clear to 0.
  - Start pulses, `stall`, `busy` and `result_valid` are 0 during and after the reset cycle.
  - The in-flight operation is abandoned with no start pulse re-issued.

## Timing

- Reset values: every output is 0.
- Cycle t: mul/div in DX, block in IDLE, `stall` = 1.
- Cycle t+1: START, start pulse high, `stall` = 1.
- Cycle t+2 onward: WAIT.
- `md_ready` sampled high in WAIT at cycle w gives DONE at w+1, with `result_valid` = 1 and `stall` = 0.
- Stall lengths:
  - Minimum: 3 cycles (t, t+1, t+2) when ready arrives in the first WAIT cycle.
  - Maximum: 2 + `MAX_CYCLES` cycles, reached on timeout.
- `md_operand_a` and `md_operand_b` are stable from t+1 through DONE.

## Test plan

- Mul with `dx_a`=7, `dx_b`=6, rd=3; `md_ready` raised 4 cycles after the start pulse with `md_result`=42 -> exactly one `md_ctrl_mult` pulse at t+1; `stall` high t..t+5; `result_valid` at t+6 with `result`=42, `result_rd`=3, `result_ovf`=0.
- Div 10/0 with `md_ready`=1 and `md_exception`=1 on the first WAIT cycle -> `md_ctrl_div` pulse; `result_valid` at t+3 with `result_ovf`=1; stall lasts 3 cycles.
- `md_ready` never asserted, `MAX_CYCLES`=40 -> DONE at t+42 with `result`=0 and `result_ovf`=1; no second start pulse.
- Two consecutive mul instructions -> two independent sequences; the second detection cycle directly follows DONE; two pulses total.
- Reset asserted during WAIT -> next cycle IDLE, all outputs 0, `stall` = 0; a later `md_ready` pulse produces no `result_valid`.
- Non-mul/div R-type add (ALU op 00000) and addi in DX -> `stall`, `busy` and both start pulses stay 0 throughout.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// ---------------------------------------------------------------------------
// multdiv_sequencer
//
// Sequences a multi-cycle multiply/divide for the 5-stage pipeline. When a
// mul or div sits in DX the block latches its operands and destination
// register, fires a one-cycle start pulse at the multdiv unit, keeps the
// front of the pipeline stalled until the unit answers (or a timeout
// expires), then presents the result for one cycle so it can be muxed into
// XM in place of the ALU output.
//
// Parameters:
//   MAX_CYCLES   WAIT cycles allowed before forcing completion with overflow
//   CNT_W        wait counter width, 2**CNT_W must exceed MAX_CYCLES
//
// Ports:
//   clock          master clock, rising edge
//   reset          synchronous active-high reset
//   dx_ir          instruction in DX
//   dx_a, dx_b     DX operands (post-bypass)
//   md_result      multdiv result
//   md_exception   multdiv exception, qualified by md_ready
//   md_ready       multdiv result-ready strobe
//   md_ctrl_mult   one-cycle multiply start pulse
//   md_ctrl_div    one-cycle divide start pulse
//   md_operand_a/b latched operands for the multdiv unit
//   stall          freeze PC/FD/DX, nop into XM
//   busy           operation in flight (START or WAIT)
//   result_valid   one-cycle result strobe (DONE)
//   result         latched result, 0 on timeout
//   result_ovf     latched exception, 1 on timeout
//   result_rd      latched destination register
// ---------------------------------------------------------------------------
module multdiv_sequencer #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_ir,
    input  logic [31:0] dx_a,
    input  logic [31:0] dx_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    output logic        stall,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        result_ovf,
    output logic [4:0]  result_rd
);

    localparam logic [4:0]       OP_RTYPE = 5'b00000;
    localparam logic [4:0]       ALU_MUL  = 5'b00110;
    localparam logic [4:0]       ALU_DIV  = 5'b00111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              md_ctrl_mult_reg;
    logic              md_ctrl_div_reg;
    logic              busy_reg;
    logic              result_valid_reg;
    logic [31:0]       operand_a_reg;
    logic [31:0]       operand_b_reg;
    logic [31:0]       result_reg;
    logic              result_ovf_reg;
    logic [4:0]        result_rd_reg;

    logic is_mul;
    logic is_div;
    logic is_md;

    // Register fields and shamt play no part in the decode.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{dx_ir[21:7], dx_ir[1:0]};

    assign is_mul = (dx_ir[31:27] == OP_RTYPE) && (dx_ir[6:2] == ALU_MUL);
    assign is_div = (dx_ir[31:27] == OP_RTYPE) && (dx_ir[6:2] == ALU_DIV);
    assign is_md  = is_mul || is_div;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= S_IDLE;
            cnt_reg          <= '0;
            md_ctrl_mult_reg <= 1'b0;
            md_ctrl_div_reg  <= 1'b0;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
            operand_a_reg    <= '0;
            operand_b_reg    <= '0;
            result_reg       <= '0;
            result_ovf_reg   <= 1'b0;
            result_rd_reg    <= '0;
        end else begin
            // Strobes are high for exactly one cycle after being set.
            md_ctrl_mult_reg <= 1'b0;
            md_ctrl_div_reg  <= 1'b0;
            result_valid_reg <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (is_md) begin
                        operand_a_reg    <= dx_a;
                        operand_b_reg    <= dx_b;
                        result_rd_reg    <= dx_ir[26:22];
                        // The pulse registers double as the latched op:
                        // they are high during START, the only cycle the
                        // op is needed.
                        md_ctrl_mult_reg <= is_mul;
                        md_ctrl_div_reg  <= is_div;
                        busy_reg         <= 1'b1;
                        state_reg        <= S_START;
                    end
                end

                S_START: begin
                    // md_ready is deliberately not looked at here.
                    cnt_reg   <= '0;
                    state_reg <= S_WAIT;
                end

                S_WAIT: begin
                    if (md_ready) begin
                        result_reg       <= md_result;
                        result_ovf_reg   <= md_exception;
                        result_valid_reg <= 1'b1;
                        busy_reg         <= 1'b0;
                        state_reg        <= S_DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        // Unit never answered: complete with an exception
                        // so the pipeline cannot hang.
                        result_reg       <= '0;
                        result_ovf_reg   <= 1'b1;
                        result_valid_reg <= 1'b1;
                        busy_reg         <= 1'b0;
                        state_reg        <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    // No decode here: the instruction still in DX is the
                    // one just completed and must not be re-issued.
                    state_reg <= S_IDLE;
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Control outputs are forced low in the reset cycle itself, not only
    // after it, so a mid-operation reset releases the pipeline at once.
    assign md_ctrl_mult = md_ctrl_mult_reg && !reset;
    assign md_ctrl_div  = md_ctrl_div_reg && !reset;
    assign busy         = busy_reg && !reset;
    assign result_valid = result_valid_reg && !reset;

    // The detection cycle stalls combinationally so DX does not advance
    // before START latches the operands.
    assign stall = !reset && (((state_reg == S_IDLE) && is_md) || busy_reg);

    assign md_operand_a = operand_a_reg;
    assign md_operand_b = operand_b_reg;
    assign result       = result_reg;
    assign result_ovf   = result_ovf_reg;
    assign result_rd    = result_rd_reg;

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

    localparam int MAX = 40;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;
    localparam logic [4:0] OP_ADDI = 5'b00101;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dx_ir = '0;
    logic [31:0] dx_a = '0;
    logic [31:0] dx_b = '0;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_ready = 1'b0;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_operand_a;
    logic [31:0] md_operand_b;
    logic        stall;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic        result_ovf;
    logic [4:0]  result_rd;

    multdiv_sequencer #(.MAX_CYCLES(MAX), .CNT_W(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .dx_ir        (dx_ir),
        .dx_a         (dx_a),
        .dx_b         (dx_b),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_ready     (md_ready),
        .md_ctrl_mult (md_ctrl_mult),
        .md_ctrl_div  (md_ctrl_div),
        .md_operand_a (md_operand_a),
        .md_operand_b (md_operand_b),
        .stall        (stall),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .result_ovf   (result_ovf),
        .result_rd    (result_rd)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int txn_count = 0;

    typedef struct {
        logic        mult;
        logic [31:0] a;
        logic [31:0] b;
    } start_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic [4:0]  rd;
        int          len;
    } exp_t;

    start_t start_q[$];
    exp_t   res_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_ctrl"}, 32'({stall, busy, md_ctrl_mult, md_ctrl_div, result_valid}), 32'd0);
        chk({name, "_result"}, result, 32'd0);
        chk({name, "_ovf_rd"}, 32'({result_ovf, result_rd}), 32'd0);
        chk({name, "_opa"}, md_operand_a, 32'd0);
        chk({name, "_opb"}, md_operand_b, 32'd0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          run_len = 0;
    bit          have_cur = 0;
    logic [31:0] cur_a;
    logic [31:0] cur_b;
    start_t      s_pop;
    exp_t        r_pop;

    always @(negedge clock) begin
        if (reset) begin
            run_len  = 0;
            have_cur = 0;
            chk("reset_outputs", 32'({stall, busy, md_ctrl_mult, md_ctrl_div, result_valid}), 32'd0);
        end else begin
            if (md_ctrl_mult || md_ctrl_div) begin
                if (start_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start: got mult=%b div=%b required no pulse",
                             md_ctrl_mult, md_ctrl_div);
                end else begin
                    s_pop = start_q.pop_front();
                    chk("start_op", 32'({md_ctrl_mult, md_ctrl_div}), 32'({s_pop.mult, !s_pop.mult}));
                    chk("start_opa", md_operand_a, s_pop.a);
                    chk("start_opb", md_operand_b, s_pop.b);
                    cur_a    = s_pop.a;
                    cur_b    = s_pop.b;
                    have_cur = 1;
                end
            end
            if ((busy || result_valid) && have_cur) begin
                chk("opa_hold", md_operand_a, cur_a);
                chk("opb_hold", md_operand_b, cur_b);
            end
            if (stall) run_len++;
            if (result_valid) begin
                chk("stall_in_done", 32'(stall), 32'd0);
                if (res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got result_valid=1 result=0x%0h required none", result);
                end else begin
                    r_pop = res_q.pop_front();
                    chk("result", result, r_pop.res);
                    chk("result_ovf", 32'(result_ovf), 32'(r_pop.ovf));
                    chk("result_rd", 32'(result_rd), 32'(r_pop.rd));
                    chk("stall_len", 32'(run_len), 32'(r_pop.len));
                    txn_count++;
                    $display("txn %0d: rd=%0d result=0x%08h ovf=%b stall_cycles=%0d",
                             txn_count, result_rd, result, result_ovf, run_len);
                end
                run_len  = 0;
                have_cur = 0;
            end else if (!stall && run_len > 0) begin
                checks++;
                failures++;
                $display("FAIL stall_orphan: got stall ended after %0d cycles without result_valid, required a result",
                         run_len);
                run_len = 0;
            end
        end
    end

    // ---------------- driver ----------------
    // delay: md_ready is raised in the delay-th cycle after the start pulse
    // (1 = first WAIT cycle); 0 = never. abort_at: cycle after detection at
    // which reset is asserted (0 = none).
    task automatic issue(input logic [4:0] opcode, input logic [4:0] alu,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input int delay, input logic [31:0] res, input logic exc,
                         input int abort_at);
        bit     md;
        bit     seen;
        bit     rdy;
        exp_t   e;
        start_t s;
        md = (opcode == 5'd0) && (alu == ALU_MUL || alu == ALU_DIV);

        @(posedge clock); #1;
        md_ready     = 1'b0;
        md_exception = 1'b0;
        md_result    = $urandom;
        dx_ir = {opcode, rd, 5'($urandom), 5'($urandom), 5'($urandom), alu, 2'b00};
        dx_a  = a;
        dx_b  = b;

        if (!md) begin
            for (int c = 1; c <= 3; c++) begin
                @(posedge clock); #1;
                md_ready  = 1'($urandom_range(0, 1));
                md_result = $urandom;
            end
            $display("txn ignored: ir=0x%08h", dx_ir);
            return;
        end

        s.mult = (alu == ALU_MUL);
        s.a    = a;
        s.b    = b;
        start_q.push_back(s);
        if (abort_at == 0) begin
            if (delay >= 1 && delay <= MAX) begin
                e.res = res;
                e.ovf = exc;
                e.len = 2 + delay;
            end else begin
                e.res = 32'd0;
                e.ovf = 1'b1;
                e.len = 2 + MAX;
            end
            e.rd = rd;
            res_q.push_back(e);
        end

        seen = 0;
        for (int c = 1; c <= MAX + 8 && !seen; c++) begin
            @(posedge clock); #1;
            dx_a = $urandom;
            dx_b = $urandom;
            if (abort_at != 0 && c == abort_at) begin
                reset    = 1'b1;
                dx_ir    = 32'd0;
                md_ready = 1'b0;
                @(posedge clock); #1;
                reset = 1'b0;
                check_all_zero("after_abort");
                md_ready     = 1'b1;
                md_result    = $urandom;
                md_exception = 1'b1;
                @(posedge clock); #1;
                md_ready = 1'b0;
                repeat (3) @(posedge clock);
                $display("txn aborted by reset at cycle %0d", c);
                return;
            end
            rdy = (delay >= 1 && c == 1 + delay) || (c == 1 && $urandom_range(0, 1) == 1);
            md_ready     = rdy;
            md_result    = (delay >= 1 && c == 1 + delay) ? res : $urandom;
            md_exception = (delay >= 1 && c == 1 + delay) ? exc : 1'($urandom);
            @(negedge clock);
            if (result_valid) seen = 1;
        end
        if (!seen && abort_at == 0) begin
            checks++;
            failures++;
            $display("FAIL result_wait: got no result_valid within %0d cycles, required one", MAX + 8);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind;
        int dly;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_all_zero("post_reset");

        // directed cases
        issue(5'd0, ALU_MUL, 32'd7, 32'd6, 5'd3, 4, 32'd42, 1'b0, 0);
        issue(5'd0, ALU_DIV, 32'd10, 32'd0, 5'd9, 1, 32'd0, 1'b1, 0);
        issue(5'd0, ALU_MUL, 32'd3, 32'd5, 5'd1, 0, 32'd15, 1'b0, 0);
        issue(5'd0, ALU_DIV, 32'd100, 32'd7, 5'd31, MAX, 32'd14, 1'b0, 0);
        issue(5'd0, ALU_MUL, 32'd2, 32'd2, 5'd8, MAX + 1, 32'd4, 1'b0, 0);
        issue(5'd0, ALU_MUL, 32'd11, 32'd12, 5'd5, 2, 32'd132, 1'b0, 0);
        issue(5'd0, ALU_MUL, 32'd13, 32'd14, 5'd6, 3, 32'd182, 1'b0, 0);
        issue(5'd0, ALU_MUL, 32'd5, 32'd5, 5'd4, 0, 32'd0, 1'b0, 5);
        issue(5'd0, 5'b00000, 32'd1, 32'd2, 5'd7, 0, 32'd0, 1'b0, 0);
        issue(OP_ADDI, ALU_MUL, 32'd1, 32'd2, 5'd7, 0, 32'd0, 1'b0, 0);
        issue(5'd0, ALU_DIV, 32'd9, 32'd3, 5'd2, 2, 32'd3, 1'b0, 0);

        // randomized traffic
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 9);
            dly  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12);
            if (kind < 4)
                issue(5'd0, ALU_MUL, $urandom, $urandom, 5'($urandom), dly, $urandom, 1'($urandom), 0);
            else if (kind < 7)
                issue(5'd0, ALU_DIV, $urandom, $urandom, 5'($urandom), dly, $urandom, 1'($urandom), 0);
            else if (kind < 8)
                issue(5'd0, 5'($urandom_range(8, 31)), $urandom, $urandom, 5'($urandom), 0, 32'd0, 1'b0, 0);
            else if (kind < 9)
                issue(5'($urandom_range(1, 31)), ALU_DIV, $urandom, $urandom, 5'($urandom), 0, 32'd0, 1'b0, 0);
            else
                issue(5'd0, ALU_MUL, $urandom, $urandom, 5'($urandom), 0, 32'd0, 1'b0, $urandom_range(2, 6));
        end

        @(posedge clock); #1;
        dx_ir    = 32'd0;
        md_ready = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("start_q_drained", 32'(start_q.size()), 32'd0);
        chk("res_q_drained", 32'(res_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
